// File: rtl/operand_stage_if.sv
// rtl/operand_stage_if.sv - issue, writeback and ALU-side handshake bundle for the operand stage
interface operand_stage_if #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32,
    parameter int AW    = 5
);
    logic             InValid;
    logic             InReady;
    logic [AW-1:0]    RA1;
    logic [AW-1:0]    RA2;
    logic [AW-1:0]    RD;
    logic [3:0]       ALUSelIn;
    logic [WIDTH-1:0] Imm;
    logic             UseImm;
    logic             WE;
    logic [AW-1:0]    WA;
    logic [WIDTH-1:0] WD;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] OP1;
    logic [WIDTH-1:0] OP2;
    logic [3:0]       ALUSel;
    logic [AW-1:0]    RDOut;
    logic [NREG-1:0]  Pending;

    modport master (
        output InValid, RA1, RA2, RD, ALUSelIn, Imm, UseImm, WE, WA, WD, OutReady,
        input  InReady, OutValid, OP1, OP2, ALUSel, RDOut, Pending
    );

    modport slave (
        input  InValid, RA1, RA2, RD, ALUSelIn, Imm, UseImm, WE, WA, WD, OutReady,
        output InReady, OutValid, OP1, OP2, ALUSel, RDOut, Pending
    );
endinterface

// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - register file read, scoreboard hazard check and operand register for the ALU
module operand_stage #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32,
    parameter int AW    = 5
) (
    input logic           CLK,
    input logic           RSTn,
    operand_stage_if.slave bus
);
    localparam logic [3:0] NOP = 4'b0111;

    logic [WIDTH-1:0] rf [NREG];
    logic [NREG-1:0]  pending;
    logic [NREG-1:0]  pend_next;
    logic [NREG-1:0]  clr_mask;
    logic [NREG-1:0]  set_mask;
    logic [NREG-1:0]  pend_eff;
    logic             out_valid;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic [3:0]       sel_q;
    logic [AW-1:0]    rd_q;
    logic             wb;
    logic             hazard;
    logic             ready;
    logic             issue;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;

    assign wb = bus.WE && (bus.WA != '0);

    // Writeback bypasses both the register file read and the scoreboard in the same cycle.
    always_comb begin
        src1 = '0;
        src2 = '0;
        if (bus.RA1 != '0)
            src1 = (wb && bus.WA == bus.RA1) ? bus.WD : rf[bus.RA1];
        if (bus.RA2 != '0)
            src2 = (wb && bus.WA == bus.RA2) ? bus.WD : rf[bus.RA2];
    end

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb)
            clr_mask[bus.WA] = 1'b1;
        if (issue && bus.RD != '0)
            set_mask[bus.RD] = 1'b1;
        pend_eff  = pending & ~clr_mask;
        pend_next = pend_eff | set_mask;
        pend_next[0] = 1'b0;
    end

    always_comb begin
        hazard = 1'b0;
        if (bus.RA1 != '0 && pend_eff[bus.RA1])
            hazard = 1'b1;
        if (!bus.UseImm && bus.RA2 != '0 && pend_eff[bus.RA2])
            hazard = 1'b1;
        if (bus.RD != '0 && pend_eff[bus.RD])
            hazard = 1'b1;
    end

    assign ready = !hazard && (!out_valid || bus.OutReady);
    assign issue = bus.InValid && ready;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
            pending   <= '0;
            out_valid <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            sel_q     <= NOP;
            rd_q      <= '0;
        end else begin
            if (wb)
                rf[bus.WA] <= bus.WD;
            pending <= pend_next;
            if (issue) begin
                out_valid <= 1'b1;
                op1_q     <= src1;
                op2_q     <= bus.UseImm ? bus.Imm : src2;
                sel_q     <= bus.ALUSelIn;
                rd_q      <= bus.RD;
            end else if (out_valid && bus.OutReady) begin
                out_valid <= 1'b0;
                sel_q     <= NOP;
            end
        end
    end

    assign bus.InReady  = ready;
    assign bus.OutValid = out_valid;
    assign bus.OP1      = op1_q;
    assign bus.OP2      = op2_q;
    assign bus.ALUSel   = sel_q;
    assign bus.RDOut    = rd_q;
    assign bus.Pending  = pending;
endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameter: WIDTH, 32, data width of registers and operands.
REQ-002 Parameter: NREG, 32, number of architectural registers.
REQ-003 Parameter: AW, 5, register address width (log2 NREG).
REQ-004 CLK  input  1  single clock, all state updates on rising edge.
REQ-005 RSTn  input  1  reset, asynchronous, active-low.
REQ-006 InValid  input  1  upstream presents an operation this cycle.
REQ-007 InReady  output  1  stage accepts the presented operation this cycle.
REQ-008 RA1, RA2  input  AW  source register addresses.
REQ-009 RD  input  AW  destination register address of the operation.
REQ-010 ALUSelIn  input  4  ALU operation code to forward.
REQ-011 Imm  input  WIDTH  immediate operand.
REQ-012 UseImm  input  1  1 = OP2 takes Imm instead of register RA2.
REQ-013 WE, WA, WD  input  1/AW/WIDTH  writeback port from ALU result Res.
REQ-014 OutValid  output  1  OP1/OP2/ALUSel/RDOut hold a valid operation.
REQ-015 OutReady  input  1  downstream ALU stage consumes the output this cycle.
REQ-016 OP1, OP2  output  WIDTH  registered operands driving ALU OP1/OP2.
REQ-017 ALUSel  output  4  registered operation code driving ALU ALUSel.
REQ-018 RDOut  output  AW  registered destination tag for writeback.
REQ-019 Pending  output  NREG  scoreboard bit vector, bit i = register i awaiting writeback.

Function
REQ-020 Register file: NREG x WIDTH, register 0 reads 0 always; writes to WA=0 ignored.
REQ-021 Write: when WE=1 and WA!=0, reg[WA] <= WD at rising CLK.
REQ-022 Read is write-first: if WE=1, WA!=0 and WA equals RA1/RA2 in the same cycle, the operand captured is WD.
REQ-023 Hazard = (RA1!=0 and Pending[RA1]) or (!UseImm and RA2!=0 and Pending[RA2]) or (RD!=0 and Pending[RD]), with bits cleared by the same-cycle writeback treated as already clear.
REQ-024 InReady = !Hazard and (!OutValid or OutReady); combinational, independent of InValid.
REQ-025 Issue occurs when InValid and InReady: next cycle OP1=src1, OP2=(UseImm ? Imm : src2), ALUSel=ALUSelIn, RDOut=RD, OutValid=1; latency exactly 1 cycle.
REQ-026 On issue with RD!=0, Pending[RD] <= 1.
REQ-027 WE=1 with WA!=0 clears Pending[WA]; if issue sets and writeback clears the same bit in one cycle, set wins.
REQ-028 Pending[0] is constantly 0.
REQ-029 OutValid=1 and OutReady=0: OP1, OP2, ALUSel, RDOut, OutValid held unchanged.
REQ-030 OutValid=1, OutReady=1, no issue: OutValid <= 0, ALUSel <= 4'b0111 (NOP), other outputs hold.
REQ-031 OutReady=1 with simultaneous issue: new operation replaces old with no bubble; full throughput 1 op/cycle.
REQ-032 InValid=0 or Hazard=1: no state change other than writeback and downstream handshake.

Reset
REQ-033 RSTn=0 immediately and asynchronously: all registers 0, Pending 0, OutValid 0, OP1 0, OP2 0, RDOut 0, ALUSel 4'b0111.
REQ-034 Reset mid-operation discards the in-flight operation and all pending tags; no writeback is required afterwards.
REQ-035 First issue possible on the first rising CLK after RSTn deasserts.

Verification
REQ-036 WE=1, WA=3, WD=0x0000_00AA; next cycle issue RA1=3, RA2=0, RD=4, ALUSelIn=0 -> OP1=0xAA, OP2=0, ALUSel=0, RDOut=4, Pending[4]=1.
REQ-037 Issue RD=5, then RA1=5 with no writeback -> InReady=0 held; WE=1, WA=5, WD=7 -> InReady=1 that cycle, OP1=7 next cycle.
REQ-038 UseImm=1, Imm=0xFFFF_FFFF, RA2=9 with Pending[9]=1 -> no stall, OP2=0xFFFF_FFFF.
REQ-039 OutValid=1, OutReady=0 for 3 cycles, InValid=1 -> outputs stable, InReady=0; OutReady=1 -> new operation appears next cycle.
REQ-040 WE=1, WA=0, WD=0x1234 then read RA1=0 -> OP1=0; RD=0 issue -> Pending stays 0.
REQ-041 RSTn pulsed low between clock edges with OutValid=1, Pending[6]=1 -> OutValid=0, Pending=0, ALUSel=4'b0111 before next edge.
